// File: rtl/regtrace_collector.sv
// In-order register-trace collector: records are allocated at issue, filled out of order by tag,
// and retired in allocation order on the registered trace_* bus. Optional watchdog: REGTRACE_TIMEOUT_EN.
module regtrace_collector #(
    parameter int ARCH_LEN       = 32,
    parameter int NUM_LANES      = 16,
    parameter int REG_BITS       = 8,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ID_BITS       = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    // Handshakes: alloc transfers when alloc_valid && alloc_ready; fill_valid and trace_valid are
    // single-cycle qualifiers with no back-pressure.
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [ARCH_LEN-1:0]           alloc_pc,
    input  logic [2:0]                    alloc_en,
    input  logic [REG_BITS-1:0]           alloc_addr_0,
    input  logic [REG_BITS-1:0]           alloc_addr_1,
    input  logic [REG_BITS-1:0]           alloc_addr_2,
    output logic [ID_BITS-1:0]            alloc_id,
    input  logic                          fill_valid,
    input  logic [ID_BITS-1:0]            fill_id,
    input  logic [1:0]                    fill_slot,
    input  logic [NUM_LANES*ARCH_LEN-1:0] fill_data,
    output logic                          trace_valid,
    output logic [ARCH_LEN-1:0]           trace_pc,
    output logic                          trace_regs_0_enable,
    output logic [REG_BITS-1:0]           trace_regs_0_address,
    output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_0_data,
    output logic                          trace_regs_1_enable,
    output logic [REG_BITS-1:0]           trace_regs_1_address,
    output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_1_data,
    output logic                          trace_regs_2_enable,
    output logic [REG_BITS-1:0]           trace_regs_2_address,
    output logic [NUM_LANES*ARCH_LEN-1:0] trace_regs_2_data,
    output logic [ID_BITS:0]              occupancy,
    output logic                          err_fill,
    output logic                          err_timeout
);
    localparam int DW = NUM_LANES * ARCH_LEN;

    logic [ID_BITS-1:0]  head_q, tail_q;
    logic [ID_BITS:0]    occ_q;
    logic [DEPTH-1:0]    busy_q;
    logic                err_fill_q;

    logic [ARCH_LEN-1:0] pc_q   [DEPTH];
    logic [2:0]          en_q   [DEPTH];
    logic [2:0]          pend_q [DEPTH];
    logic [REG_BITS-1:0] addr_q [DEPTH][3];
    logic [DW-1:0]       data_q [DEPTH][3];

    logic                trace_valid_q;
    logic [ARCH_LEN-1:0] trace_pc_q;
    logic                tr_en_q   [3];
    logic [REG_BITS-1:0] tr_addr_q [3];
    logic [DW-1:0]       tr_data_q [3];

    logic alloc_fire, retire, fill_ok;
    logic [REG_BITS-1:0] alloc_addr [3];

    assign alloc_addr[0] = alloc_addr_0;
    assign alloc_addr[1] = alloc_addr_1;
    assign alloc_addr[2] = alloc_addr_2;

    // Full is judged on registered occupancy, so a same-cycle retire never frees a slot early.
    assign alloc_ready = (occ_q != (ID_BITS+1)'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_id    = tail_q;
    assign retire      = busy_q[head_q] && (pend_q[head_q] == 3'b000);

    always_comb begin
        fill_ok = 1'b0;
        case (fill_slot)
            2'd0:    fill_ok = pend_q[fill_id][0];
            2'd1:    fill_ok = pend_q[fill_id][1];
            2'd2:    fill_ok = pend_q[fill_id][2];
            default: fill_ok = 1'b0;
        endcase
        fill_ok = fill_ok && busy_q[fill_id];
    end

    // Record payload needs no reset: busy gates every use of it.
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            pc_q[tail_q]   <= alloc_pc;
            en_q[tail_q]   <= alloc_en;
            pend_q[tail_q] <= alloc_en;
            for (int k = 0; k < 3; k++) addr_q[tail_q][k] <= alloc_addr[k];
        end
        if (fill_valid && fill_ok) begin
            pend_q[fill_id][fill_slot] <= 1'b0;
            for (int k = 0; k < 3; k++)
                if (fill_slot == 2'(k)) data_q[fill_id][k] <= fill_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            occ_q         <= '0;
            busy_q        <= '0;
            err_fill_q    <= 1'b0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            for (int k = 0; k < 3; k++) begin
                tr_en_q[k]   <= 1'b0;
                tr_addr_q[k] <= '0;
                tr_data_q[k] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                busy_q[tail_q] <= 1'b1;
                tail_q         <= tail_q + 1'b1;
            end
            if (fill_valid && !fill_ok) err_fill_q <= 1'b1;
            trace_valid_q <= retire;
            if (retire) begin
                busy_q[head_q] <= 1'b0;
                head_q         <= head_q + 1'b1;
                trace_pc_q     <= pc_q[head_q];
                for (int k = 0; k < 3; k++) begin
                    tr_en_q[k]   <= en_q[head_q][k];
                    tr_addr_q[k] <= en_q[head_q][k] ? addr_q[head_q][k] : '0;
                    tr_data_q[k] <= en_q[head_q][k] ? data_q[head_q][k] : '0;
                end
            end
            case ({alloc_fire, retire})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

`ifdef REGTRACE_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_BITS-1:0] to_cnt_q;
    logic               err_timeout_q;

    // A busy head that does not retire this cycle is by definition incomplete.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else if (retire || occ_q == '0) begin
            to_cnt_q <= '0;
        end else if (busy_q[head_q]) begin
            if (to_cnt_q != TO_BITS'(TIMEOUT_CYCLES)) to_cnt_q <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_BITS'(TIMEOUT_CYCLES - 1)) err_timeout_q <= 1'b1;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign trace_valid          = trace_valid_q;
    assign trace_pc             = trace_pc_q;
    assign trace_regs_0_enable  = tr_en_q[0];
    assign trace_regs_0_address = tr_addr_q[0];
    assign trace_regs_0_data    = tr_data_q[0];
    assign trace_regs_1_enable  = tr_en_q[1];
    assign trace_regs_1_address = tr_addr_q[1];
    assign trace_regs_1_data    = tr_data_q[1];
    assign trace_regs_2_enable  = tr_en_q[2];
    assign trace_regs_2_address = tr_addr_q[2];
    assign trace_regs_2_data    = tr_data_q[2];
    assign occupancy            = occ_q;
    assign err_fill             = err_fill_q;
endmodule

// File: tb/tb_regtrace_collector.sv
// Directed bench for regtrace_collector; the timeout scenario follows REGTRACE_TIMEOUT_EN.
module tb_regtrace_collector;
    localparam int ARCH_LEN = 32;
    localparam int NUM_LANES = 16;
    localparam int REG_BITS = 8;
    localparam int DEPTH = 8;
    localparam int ID_BITS = 3;
    localparam int DW = NUM_LANES * ARCH_LEN;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic alloc_valid = 1'b0;
    logic alloc_ready;
    logic [ARCH_LEN-1:0] alloc_pc = '0;
    logic [2:0] alloc_en = '0;
    logic [REG_BITS-1:0] alloc_addr_0 = '0, alloc_addr_1 = '0, alloc_addr_2 = '0;
    logic [ID_BITS-1:0] alloc_id;
    logic fill_valid = 1'b0;
    logic [ID_BITS-1:0] fill_id = '0;
    logic [1:0] fill_slot = '0;
    logic [DW-1:0] fill_data = '0;
    logic trace_valid;
    logic [ARCH_LEN-1:0] trace_pc;
    logic trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable;
    logic [REG_BITS-1:0] trace_regs_0_address, trace_regs_1_address, trace_regs_2_address;
    logic [DW-1:0] trace_regs_0_data, trace_regs_1_data, trace_regs_2_data;
    logic [ID_BITS:0] occupancy;
    logic err_fill, err_timeout;

    int n_checks = 0;
    int n_fail = 0;

    regtrace_collector #(
        .ARCH_LEN(ARCH_LEN), .NUM_LANES(NUM_LANES), .REG_BITS(REG_BITS),
        .DEPTH(DEPTH), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_en(alloc_en), .alloc_addr_0(alloc_addr_0), .alloc_addr_1(alloc_addr_1),
        .alloc_addr_2(alloc_addr_2), .alloc_id(alloc_id),
        .fill_valid(fill_valid), .fill_id(fill_id), .fill_slot(fill_slot), .fill_data(fill_data),
        .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_regs_0_enable(trace_regs_0_enable), .trace_regs_0_address(trace_regs_0_address),
        .trace_regs_0_data(trace_regs_0_data),
        .trace_regs_1_enable(trace_regs_1_enable), .trace_regs_1_address(trace_regs_1_address),
        .trace_regs_1_data(trace_regs_1_data),
        .trace_regs_2_enable(trace_regs_2_enable), .trace_regs_2_address(trace_regs_2_address),
        .trace_regs_2_data(trace_regs_2_data),
        .occupancy(occupancy), .err_fill(err_fill), .err_timeout(err_timeout)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alloc_valid = 1'b0;
        fill_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] lanes(input logic [31:0] base);
        logic [DW-1:0] d;
        for (int g = 0; g < NUM_LANES; g++) d[ARCH_LEN*g +: ARCH_LEN] = base + 32'(g);
        return d;
    endfunction

    // driver tasks
    task automatic set_alloc(input logic [31:0] pc, input logic [2:0] en,
                             input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        alloc_valid = 1'b1;
        alloc_pc = pc;
        alloc_en = en;
        alloc_addr_0 = a0;
        alloc_addr_1 = a1;
        alloc_addr_2 = a2;
    endtask

    task automatic set_fill(input logic [2:0] id, input logic [1:0] slot, input logic [DW-1:0] d);
        fill_valid = 1'b1;
        fill_id = id;
        fill_slot = slot;
        fill_data = d;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trace_valid got %b want 0", trace_valid); end
        n_checks++; if (trace_pc !== '0) begin n_fail++; $display("FAIL reset_trace_pc got %h want 0", trace_pc); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); end
        n_checks++; if (alloc_id !== 3'd0) begin n_fail++; $display("FAIL reset_alloc_id got %0d want 0", alloc_id); end
        n_checks++; if ({err_fill, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", {err_fill, err_timeout}); end
    endtask

    task automatic test_alloc_empty();
        do_reset();
        set_alloc(32'h8000_0000, 3'b000, 8'd1, 8'd2, 8'd3);
        n_checks++; if (alloc_id !== 3'd0) begin n_fail++; $display("FAIL empty_alloc_id got %0d want 0", alloc_id); end
        step();
        alloc_valid = 1'b0;
        n_checks++; if (trace_valid !== 1'b0 || occupancy !== 4'd1) begin n_fail++; $display("FAIL empty_after_alloc got valid=%b occ=%0d want 0/1", trace_valid, occupancy); end
        step();
        n_checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL empty_retire got valid=%b pc=%h want 1/80000000", trace_valid, trace_pc); end
        n_checks++; if ({trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable} !== 3'b000 || trace_regs_0_address !== 8'd0) begin n_fail++; $display("FAIL empty_enables got %b addr0=%0d want 000/0", {trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable}, trace_regs_0_address); end
        step();
        n_checks++; if (trace_valid !== 1'b0 || trace_pc !== 32'h8000_0000 || occupancy !== 4'd0) begin n_fail++; $display("FAIL empty_hold got valid=%b pc=%h occ=%0d want 0/80000000/0", trace_valid, trace_pc, occupancy); end
    endtask

    task automatic test_fill_order();
        do_reset();
        set_alloc(32'h1000, 3'b011, 8'd5, 8'd6, 8'd9);
        step();
        alloc_valid = 1'b0;
        set_fill(3'd0, 2'd1, lanes(32'h100));
        step();
        n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL partial_no_retire got %b want 0", trace_valid); end
        set_fill(3'd0, 2'd0, lanes(32'h0));
        step();
        fill_valid = 1'b0;
        n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL fill_edge_no_retire got %b want 0", trace_valid); end
        step();
        n_checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h1000) begin n_fail++; $display("FAIL fill_retire got valid=%b pc=%h want 1/1000", trace_valid, trace_pc); end
        n_checks++; if (trace_regs_0_address !== 8'd5 || trace_regs_1_address !== 8'd6 || trace_regs_2_address !== 8'd0) begin n_fail++; $display("FAIL fill_addrs got %0d/%0d/%0d want 5/6/0", trace_regs_0_address, trace_regs_1_address, trace_regs_2_address); end
        n_checks++; if ({trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable} !== 3'b110) begin n_fail++; $display("FAIL fill_enables got %b want 110", {trace_regs_0_enable, trace_regs_1_enable, trace_regs_2_enable}); end
        n_checks++; if (trace_regs_0_data !== lanes(32'h0) || trace_regs_1_data !== lanes(32'h100) || trace_regs_2_data !== '0) begin n_fail++; $display("FAIL fill_data got lane0 %h/%h/%h want 0/100/0", trace_regs_0_data[31:0], trace_regs_1_data[31:0], trace_regs_2_data[31:0]); end
        n_checks++; if (err_fill !== 1'b0) begin n_fail++; $display("FAIL fill_no_err got %b want 0", err_fill); end
    endtask

    task automatic test_out_of_order();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(exp_pc[i], 3'b001, 8'(10 + i), 8'd0, 8'd0);
            step();
        end
        alloc_valid = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            set_fill(3'(i), 2'd0, lanes(32'(i * 1000)));
            step();
        end
        fill_valid = 1'b0;
        n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early got %b want 0", trace_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (trace_valid !== 1'b1 || trace_pc !== exp_pc[i] || trace_regs_0_address !== 8'(10 + i)) begin n_fail++; $display("FAIL ooo_retire_%0d got valid=%b pc=%h addr=%0d want 1/%h/%0d", i, trace_valid, trace_pc, trace_regs_0_address, exp_pc[i], 10 + i); end
            n_checks++; if (trace_regs_0_data !== lanes(32'(i * 1000))) begin n_fail++; $display("FAIL ooo_data_%0d got lane0 %h want %h", i, trace_regs_0_data[31:0], i * 1000); end
        end
        step();
        n_checks++; if (trace_valid !== 1'b0 || occupancy !== 4'd0) begin n_fail++; $display("FAIL ooo_drain got valid=%b occ=%0d want 0/0", trace_valid, occupancy); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(32'h200 + 32'(4 * i), 3'b001, 8'd1, 8'd0, 8'd0);
            step();
        end
        n_checks++; if (alloc_ready !== 1'b0 || occupancy !== 4'd8 || alloc_id !== 3'd0) begin n_fail++; $display("FAIL full_state got ready=%b occ=%0d id=%0d want 0/8/0", alloc_ready, occupancy, alloc_id); end
        set_alloc(32'h300, 3'b001, 8'd2, 8'd0, 8'd0);
        set_fill(3'd0, 2'd0, lanes(32'h55));
        step();
        fill_valid = 1'b0;
        n_checks++; if (alloc_ready !== 1'b0 || occupancy !== 4'd8 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL full_blocked got ready=%b occ=%0d valid=%b want 0/8/0", alloc_ready, occupancy, trace_valid); end
        step();
        n_checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h200 || occupancy !== 4'd7) begin n_fail++; $display("FAIL full_retire got valid=%b pc=%h occ=%0d want 1/200/7", trace_valid, trace_pc, occupancy); end
        n_checks++; if (alloc_ready !== 1'b1 || alloc_id !== 3'd0) begin n_fail++; $display("FAIL full_reopen got ready=%b id=%0d want 1/0", alloc_ready, alloc_id); end
        step();
        alloc_valid = 1'b0;
        n_checks++; if (occupancy !== 4'd8 || alloc_id !== 3'd1 || alloc_ready !== 1'b0 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL full_wrap got occ=%0d id=%0d ready=%b valid=%b want 8/1/0/0", occupancy, alloc_id, alloc_ready, trace_valid); end
    endtask

    task automatic test_errors();
        // unallocated id
        do_reset();
        set_fill(3'd3, 2'd0, lanes(32'h1));
        step();
        fill_valid = 1'b0;
        n_checks++; if (err_fill !== 1'b1) begin n_fail++; $display("FAIL err_unalloc got %b want 1", err_fill); end
        do_reset();
        n_checks++; if (err_fill !== 1'b0) begin n_fail++; $display("FAIL err_reset_clear got %b want 0", err_fill); end
        // slot 3 on a live record
        set_alloc(32'h400, 3'b001, 8'd7, 8'd0, 8'd0);
        step();
        alloc_valid = 1'b0;
        set_fill(3'd0, 2'd3, lanes(32'h2));
        step();
        fill_valid = 1'b0;
        step();
        n_checks++; if (err_fill !== 1'b1 || trace_valid !== 1'b0 || occupancy !== 4'd1) begin n_fail++; $display("FAIL err_slot3 got err=%b valid=%b occ=%0d want 1/0/1", err_fill, trace_valid, occupancy); end
        // duplicate fill, then reset discards the pending record
        do_reset();
        set_alloc(32'h500, 3'b011, 8'd3, 8'd4, 8'd0);
        step();
        alloc_valid = 1'b0;
        set_fill(3'd0, 2'd0, lanes(32'h3));
        step();
        n_checks++; if (err_fill !== 1'b0) begin n_fail++; $display("FAIL err_first_fill got %b want 0", err_fill); end
        step();
        fill_valid = 1'b0;
        step();
        n_checks++; if (err_fill !== 1'b1 || trace_valid !== 1'b0) begin n_fail++; $display("FAIL err_duplicate got err=%b valid=%b want 1/0", err_fill, trace_valid); end
        do_reset();
        set_fill(3'd0, 2'd1, lanes(32'h4));
        step();
        fill_valid = 1'b0;
        step();
        n_checks++; if (err_fill !== 1'b1 || trace_valid !== 1'b0 || occupancy !== 4'd0) begin n_fail++; $display("FAIL err_after_reset got err=%b valid=%b occ=%0d want 1/0/0", err_fill, trace_valid, occupancy); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_alloc(32'h600, 3'b001, 8'd1, 8'd0, 8'd0);
        step();
        alloc_valid = 1'b0;
`ifdef REGTRACE_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b want 0", err_timeout); end
        step();
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_rise got %b want 1", err_timeout); end
        do_reset();
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_reset got %b want 0", err_timeout); end
`else
        for (int i = 0; i < 20; i++) step();
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_disabled got %b want 0", err_timeout); end
`endif
    endtask

    initial begin
        test_reset();
        test_alloc_empty();
        test_fill_order();
        test_out_of_order();
        test_full();
        test_errors();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regtrace_collector.md
# regtrace_collector

In-order register-trace collector on the core side of the Cyclotron difftest path. The issue stage allocates one record per instruction: PC plus up to three register slots. Execution units fill slot data out of order by record tag. Completed records are retired strictly in allocation order on the `trace_*` bus consumed by the difftest blackbox, at most one per cycle.

## Interface
- `ARCH_LEN`, 32, lane data / PC width
- `NUM_LANES`, 16, lanes per register slot
- `REG_BITS`, 8, register address width
- `DEPTH`, 8, record entries (power of two, ≥2)
- `TIMEOUT_CYCLES`, 1024, watchdog limit (used only with `REGTRACE_TIMEOUT_EN`)
- `ID_BITS` (local), `$clog2(DEPTH)`

Ports:
- `clock`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `alloc_valid`  in  1  issue offers a record
- `alloc_ready`  out  1  `!full`
- `alloc_pc`  in  `ARCH_LEN`  instruction PC
- `alloc_en`  in  3  slot-enable bits; bit k enables slot k
- `alloc_addr_0`, `alloc_addr_1`, `alloc_addr_2`  in  `REG_BITS`  slot register addresses
- `alloc_id`  out  `ID_BITS`  tag assigned on handshake (equals the tail pointer)
- `fill_valid`  in  1  slot data write
- `fill_id`  in  `ID_BITS`  target record
- `fill_slot`  in  2  slot index 0..2
- `fill_data`  in  `NUM_LANES*ARCH_LEN`  lane-packed data; lane g at `[ARCH_LEN*g +: ARCH_LEN]`
- `trace_valid`  out  1  one-cycle retire pulse
- `trace_pc`  out  `ARCH_LEN`
- `trace_regs_k_enable`, `trace_regs_k_address`, `trace_regs_k_data` (k = 0..2)  out  1 / `REG_BITS` / `NUM_LANES*ARCH_LEN`
- `occupancy`  out  `ID_BITS+1`  live records
- `err_fill`  out  1  sticky protocol error
- `err_timeout`  out  1  sticky watchdog flag (tied 0 without the macro)

## Operation
- Each entry holds: `busy`, `pc`, `en[2:0]`, three addresses, three data words, and `pend[2:0]`.
- Allocation:
  - Fires on `alloc_valid && alloc_ready`.
  - Writes the entry at `tail`, sets `busy`, and sets `pend = alloc_en`.
  - `tail` increments and wraps mod `DEPTH`.
- Fill:
  - Fires on `fill_valid`.
  - If the entry is busy, the slot < 3, and its `pend` bit is set: store the data and clear the `pend` bit.
  - Otherwise: drop the write and set `err_fill`. This covers an unallocated id, slot 3, a disabled slot, and a duplicate fill.
- Complete: `busy && pend == 0`. A record with `alloc_en = 0` is complete immediately.
- Retire:
  - When `head` is complete, copy the head entry into the `trace_*` output registers and pulse `trace_valid`.
  - Clear `busy` and increment `head`.
- Disabled-slot outputs on retire: `enable = 0`, address and data = 0.

## Timing
- Reset (synchronous):
  - Outputs: `trace_valid` 0; all `trace_*` 0; `occupancy` 0; `err_*` 0; `alloc_ready` 1; `alloc_id` 0.
  - Internal: `head = tail = 0`, all `busy` cleared.
  - Reset mid-operation discards all records and emits no trace.
- `trace_*` outputs are registered.
- Retire latency:
  - A record retires at the earliest 1 cycle after its allocation edge.
  - A fill completing the head produces `trace_valid` on the next cycle.
- `trace_valid` is high for exactly one cycle per record. Back-to-back completed records retire on consecutive cycles.
- `trace_*` hold their last values while `trace_valid` is 0.
- `alloc_ready` is computed from registered occupancy. When full, no allocation occurs even if a retire happens in the same cycle.
- Same-cycle events:
  - Alloc and retire: occupancy unchanged.
  - Fill to the head in the retire cycle: impossible, since retire requires `pend == 0`, so the fill is a duplicate and flags `err_fill`.
  - Fill to the id being allocated in the same cycle: the entry is not yet busy, so the fill flags `err_fill`.
- Pointers wrap silently. Full = `occupancy == DEPTH`; empty = 0.

## Configuration
- `REGTRACE_TIMEOUT_EN` defined:
  - A counter resets on every retire and while empty.
  - It increments while the head is busy but incomplete.
  - Reaching `TIMEOUT_CYCLES` sets `err_timeout` (sticky until reset).
- Not defined: no counter; `err_timeout` is constant 0.

## Test plan
- Reset, then alloc `pc=0x80000000`, `en=0` -> `alloc_id=0`; `trace_valid` next cycle with `pc=0x80000000` and all enables 0.
- Alloc id0 (`en=3'b011`, addr 5/6), then fill slot1 and then slot0 with lane g = g -> retire the cycle after the slot0 fill; `regs_0_address=5`, `regs_1_address=6`, `regs_2_enable=0`.
- Alloc ids 0,1,2; fill id2, then id1, then id0 -> retires occur in order 0,1,2 on three consecutive cycles after the id0 fill.
- Allocate `DEPTH` records without fills -> `alloc_ready=0`, `occupancy=8`; one fill completing the head -> `alloc_ready` returns 1 one cycle after retire; `alloc_id` wraps to 0.
- Fill unallocated id 3, then fill with slot=3, then a duplicate fill -> `err_fill` set and no trace emitted; reset clears it.
- With `REGTRACE_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`: alloc `en=1` with no fill -> `err_timeout` rises after 16 cycles; without the macro it stays 0.
